angular_filter_accum: RTL and testbench
=======================================

Name: angular_filter_accum

Overview:
- Downstream neighbour of the MCM constant-multiplier stage in the intra angular sample path.
- Takes the four signed tap products of one predicted sample (one product per reference sample, each chosen from an MCM output) and sums them. It then rounds, shifts and clips the result to a BIT_DEPTH prediction sample.
- Registered 2-stage pipeline with a valid/ready handshake on both sides and a per-row sample counter that flags the last sample of each row.

Parameters:
- BIT_DEPTH, 8, output sample width; clip range 0..2^BIT_DEPTH-1.
- PROD_W, 16, width of each signed tap product.
- SHIFT, 6, normalisation shift (filter coefficients sum to 64).
- N_SAMPLES, 32, samples per row; sets the out_last period.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear of pipeline and counter.
- in_valid  in  1  tap products valid.
- in_ready  out  1  stage can accept.
- in_p0  in  PROD_W  signed tap-0 product.
- in_p1  in  PROD_W  signed tap-1 product.
- in_p2  in  PROD_W  signed tap-2 product.
- in_p3  in  PROD_W  signed tap-3 product.
- out_valid  out  1  out_sample valid.
- out_ready  in  1  consumer accepts.
- out_sample  out  BIT_DEPTH  unsigned clipped prediction sample.
- out_last  out  1  last sample of row.
- out_idx  out  $clog2(N_SAMPLES)  position of out_sample within the row.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all valid flags 0, out_sample 0, out_last 0, out_idx 0, counter 0, pipeline data registers 0.
- Advance enable: en = !out_valid || out_ready. in_ready = en && !flush, combinational.
- Input accept: on in_valid && in_ready.
- Stage S1 (when en): s1_a = p0+p1 and s1_b = p2+p3, both sign-extended to PROD_W+1. s1_valid <= in_valid && in_ready.
- Stage S2 (when en): sum = s1_a + s1_b at PROD_W+2 (18) bits; no overflow is possible.
- Rounding: r = (sum + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift.
- Clip: r < 0 gives 0; r > 2^BIT_DEPTH-1 gives 2^BIT_DEPTH-1; otherwise r. The result goes to out_sample. out_valid <= s1_valid.
- Latency: 2 cycles from input accept to out_valid when there are no stalls. Throughput is 1 sample per cycle.
- Stall: when out_valid && !out_ready, the whole pipeline holds.
  - out_sample, out_last and out_idx stay stable.
  - in_ready is 0.
  - No sample is lost or duplicated.
- Bubbles: an empty S1 advances into S2 whenever en is high, so bubbles collapse.
- Row counter:
  - Increments on each output handshake (out_valid && out_ready).
  - Wraps from N_SAMPLES-1 to 0.
  - out_idx = counter. out_last = out_valid && (counter == N_SAMPLES-1).
- Flush (synchronous, highest priority after reset):
  - Clears s1_valid, out_valid and the counter on the next edge.
  - Any input presented with flush is not accepted, because in_ready is 0.
  - An output handshake in the same cycle still counts as consumed by the consumer, but the counter ends at 0.
- Reset mid-operation: all in-flight samples are discarded immediately. The first post-reset sample has out_idx 0.
- in_p* and in_valid are don't-care when the input is not accepted.

Decomposition:
- Package angular_pkg holds:
  - constants BIT_DEPTH_DEF = 8, PROD_W = 16, SUM_W = 18, FILT_SHIFT = 6, ROUND_OFS = 32;
  - typedefs prod_t (signed [15:0]), sum_t (signed [17:0]), pel_t ([7:0]);
  - function clip_pel.
- Sub-module round_shift_clip (combinational: sum_t in, pel_t out) is instantiated once in S2. It is reused by later bilinear/DC stages.

Test Plan:
- Basic: p = {0, 6400, 0, 0}, out_ready = 1. Required: out_sample = 100, two cycles after accept, out_idx = 0.
- Rounding boundary: sums 31, 32 and 95 via p0 only. Required: out_sample 0, 1, 1. Sum -33 gives 0.
- Clip: p = {32767, 32767, 0, 0} gives 255. p = {-3000, 0, 0, 0} gives 0.
- Backpressure:
  - Stream 5 samples with out_ready held low for 3 cycles mid-stream.
  - Required: in_ready is 0 during the stall and outputs hold stable.
  - All 5 samples appear in order, with no loss or duplication.
- Row framing: 70 back-to-back samples. Required:
  - out_last is high only on output #32 and #64 (out_idx = 31);
  - out_idx wraps to 0 on #33;
  - no last flag on #70.
- Flush/reset: flush while 2 samples are in flight. Required:
  - out_valid is 0 next cycle;
  - the next sample has out_idx 0.
  - Repeating with rst_n asserted asynchronously between edges clears the outputs immediately.

Source files
------------

// File: rtl/angular_pkg.sv
// ---------------------------------------------------------------------------
// angular_pkg
// Shared constants and types for the intra angular sample path.
//   BIT_DEPTH_DEF : default prediction sample width
//   PROD_W        : width of one signed tap product from the MCM stage
//   SUM_W         : width of the four-tap sum (two bits of headroom)
//   FILT_SHIFT    : normalisation shift (filter taps sum to 64)
//   ROUND_OFS     : rounding offset added before the shift
// clip_pel clamps an already normalised value into the default pixel range.
// ---------------------------------------------------------------------------
package angular_pkg;

    localparam int BIT_DEPTH_DEF = 8;
    localparam int PROD_W        = 16;
    localparam int SUM_W         = 18;
    localparam int FILT_SHIFT    = 6;
    localparam int ROUND_OFS     = 32;

    typedef logic signed [PROD_W-1:0]     prod_t;
    typedef logic signed [SUM_W-1:0]      sum_t;
    typedef logic [BIT_DEPTH_DEF-1:0]     pel_t;

    // Clamp a normalised signed value into 0..2^BIT_DEPTH_DEF-1.
    function automatic pel_t clip_pel(input sum_t r);
        localparam sum_t PEL_MAX = sum_t'((2 ** BIT_DEPTH_DEF) - 1);
        pel_t res;
        if (r < 0) begin
            res = '0;
        end else if (r > PEL_MAX) begin
            res = '1;
        end else begin
            res = r[BIT_DEPTH_DEF-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/round_shift_clip.sv
// ---------------------------------------------------------------------------
// round_shift_clip
// Combinational round-half-up, arithmetic right shift and clip of a signed
// filter sum to an unsigned prediction sample. Shared by the angular,
// bilinear and DC stages.
//   sum_in  : signed filter sum (IN_W bits)
//   pel_out : unsigned clipped sample (OUT_W bits)
// ---------------------------------------------------------------------------
module round_shift_clip
    import angular_pkg::*;
#(
    parameter int IN_W      = SUM_W,
    parameter int OUT_W     = BIT_DEPTH_DEF,
    parameter int SHIFT_AMT = FILT_SHIFT
) (
    input  logic signed [IN_W-1:0] sum_in,
    output logic [OUT_W-1:0]       pel_out
);

    localparam logic signed [IN_W:0] RND   = (IN_W+1)'(2 ** (SHIFT_AMT - 1));
    localparam logic signed [IN_W:0] P_MAX = (IN_W+1)'((2 ** OUT_W) - 1);

    logic signed [IN_W:0] biased;
    logic signed [IN_W:0] shifted;

    // The rounding offset is added one bit wider than the sum: a sum close
    // to the positive limit plus the offset would otherwise wrap negative
    // and clip to 0 instead of to the maximum.
    always_comb begin
        biased  = $signed({sum_in[IN_W-1], sum_in}) + RND;
        shifted = biased >>> SHIFT_AMT;
        if (shifted < 0) begin
            pel_out = '0;
        end else if (shifted > P_MAX) begin
            pel_out = '1;
        end else begin
            pel_out = shifted[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/angular_filter_accum.sv
// ---------------------------------------------------------------------------
// angular_filter_accum
// Sums the four tap products of one angular predicted sample, rounds,
// shifts and clips to a BIT_DEPTH sample. 2-stage pipeline with valid/ready
// on both sides and a per-row sample counter.
//   clk, rst_n          : clock, async active-low reset
//   flush               : synchronous clear of pipeline and row counter
//   in_valid/in_ready   : input handshake
//   in_p0..in_p3        : signed tap products
//   out_valid/out_ready : output handshake
//   out_sample          : clipped prediction sample
//   out_last            : sample is the last of its row
//   out_idx             : sample position within the row
// ---------------------------------------------------------------------------
module angular_filter_accum
    import angular_pkg::*;
#(
    parameter int BIT_DEPTH = angular_pkg::BIT_DEPTH_DEF,
    parameter int PROD_W    = angular_pkg::PROD_W,
    parameter int SHIFT     = angular_pkg::FILT_SHIFT,
    parameter int N_SAMPLES = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [PROD_W-1:0]     in_p0,
    input  logic signed [PROD_W-1:0]     in_p1,
    input  logic signed [PROD_W-1:0]     in_p2,
    input  logic signed [PROD_W-1:0]     in_p3,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [BIT_DEPTH-1:0]         out_sample,
    output logic                         out_last,
    output logic [$clog2(N_SAMPLES)-1:0] out_idx
);

    localparam int PAIR_W = PROD_W + 1;
    localparam int ACC_W  = PROD_W + 2;
    localparam int IDX_W  = $clog2(N_SAMPLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SAMPLES - 1);

    logic                     en;
    logic                     accept;
    logic                     consume;
    logic                     s1_valid;
    logic signed [PAIR_W-1:0] s1_a;
    logic signed [PAIR_W-1:0] s1_b;
    logic signed [ACC_W-1:0]  s2_sum;
    logic [BIT_DEPTH-1:0]     s2_pel;
    logic [IDX_W-1:0]         counter;

    // The whole pipeline moves together: it advances whenever the output
    // register is empty or being drained, so an empty S1 slot is simply
    // overwritten and bubbles never occupy a cycle of throughput.
    always_comb begin
        en       = !out_valid || out_ready;
        in_ready = en && !flush;
        accept   = in_valid && in_ready;
        consume  = out_valid && out_ready;
    end

    // Final add of the two pair sums; with four PROD_W products two extra
    // bits are always enough, so this cannot overflow.
    always_comb begin
        s2_sum = $signed({s1_a[PAIR_W-1], s1_a}) + $signed({s1_b[PAIR_W-1], s1_b});
    end

    round_shift_clip #(
        .IN_W      (ACC_W),
        .OUT_W     (BIT_DEPTH),
        .SHIFT_AMT (SHIFT)
    ) u_rsc (
        .sum_in  (s2_sum),
        .pel_out (s2_pel)
    );

    // Stage S1: pairwise sums of the tap products. Data is only captured on
    // an accepted input so the registers stay quiet on idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (en) begin
            s1_valid <= accept;
            if (accept) begin
                s1_a <= $signed({in_p0[PROD_W-1], in_p0}) + $signed({in_p1[PROD_W-1], in_p1});
                s1_b <= $signed({in_p2[PROD_W-1], in_p2}) + $signed({in_p3[PROD_W-1], in_p3});
            end
        end
    end

    // Stage S2: output register holding the rounded, clipped sample. While
    // stalled (en low) it keeps its value so the consumer sees a stable word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_sample <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
        end else if (en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sample <= s2_pel;
            end
        end
    end

    // Row position counter. It steps on each output handshake and wraps at
    // the row length; a flush returns it to 0 even if a sample is consumed
    // in the same cycle, so the next row always starts at index 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter <= '0;
        end else if (flush) begin
            counter <= '0;
        end else if (consume) begin
            if (counter == IDX_LAST) begin
                counter <= '0;
            end else begin
                counter <= counter + 1'b1;
            end
        end
    end

    always_comb begin
        out_idx  = counter;
        out_last = out_valid && (counter == IDX_LAST);
    end

endmodule

// File: tb/tb_angular_filter_accum.sv
// ---------------------------------------------------------------------------
// tb_angular_filter_accum
// Self-checking bench for angular_filter_accum: directed vectors with literal
// expectations plus a queue-based reference model checked every cycle.
// ---------------------------------------------------------------------------
module tb_angular_filter_accum;

    localparam int BIT_DEPTH = 8;
    localparam int PROD_W    = 16;
    localparam int SHIFT     = 6;
    localparam int N_SAMPLES = 32;
    localparam int IDX_W     = 5;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [PROD_W-1:0] in_p0, in_p1, in_p2, in_p3;
    logic                     out_valid;
    logic                     out_ready;
    logic [BIT_DEPTH-1:0]     out_sample;
    logic                     out_last;
    logic [IDX_W-1:0]         out_idx;

    int checks   = 0;
    int failures = 0;

    int expQ[$];
    int modelIdx   = 0;
    int outCount   = 0;
    int stallCycles = 0;
    int lastLog[0:127];
    int idxLog[0:127];

    bit                   stallPrev = 1'b0;
    bit                   flushPrev = 1'b0;
    logic [BIT_DEPTH-1:0] prevSample;
    logic [IDX_W-1:0]     prevIdx;
    logic                 prevLast;

    angular_filter_accum #(
        .BIT_DEPTH (BIT_DEPTH),
        .PROD_W    (PROD_W),
        .SHIFT     (SHIFT),
        .N_SAMPLES (N_SAMPLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_p0      (in_p0),
        .in_p1      (in_p1),
        .in_p2      (in_p2),
        .in_p3      (in_p3),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sample (out_sample),
        .out_last   (out_last),
        .out_idx    (out_idx)
    );

    always #5 clk = ~clk;

    // Reference: weighted sum divided by 64 with round-half-up (floor of
    // (s+32)/64), then clamped to the pixel range.
    function automatic int modelPel(input int a, input int b, input int c, input int d);
        int s;
        int q;
        s = a + b + c + d + 32;
        q = s / 64;
        if ((s % 64 != 0) && (s < 0)) q = q - 1;
        if (q < 0) q = 0;
        if (q > 255) q = 255;
        return q;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Scoreboard and protocol checker, sampled mid-cycle away from the edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            expQ.delete();
            modelIdx  = 0;
            stallPrev = 1'b0;
            flushPrev = 1'b0;
        end else begin
            if (stallPrev && !flushPrev) begin
                checkOutput("stall_hold_valid", int'(out_valid), 1);
                checkOutput("stall_hold_sample", int'(out_sample), int'(prevSample));
                checkOutput("stall_hold_idx", int'(out_idx), int'(prevIdx));
                checkOutput("stall_hold_last", int'(out_last), int'(prevLast));
            end
            if (out_valid && !out_ready) begin
                checkOutput("stall_in_ready", int'(in_ready), 0);
                stallCycles++;
            end
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("sb_unexpected_output", 1, 0);
                end else begin
                    int e;
                    e = expQ.pop_front();
                    checkOutput("sb_sample", int'(out_sample), e);
                    checkOutput("sb_idx", int'(out_idx), modelIdx);
                    checkOutput("sb_last", int'(out_last), (modelIdx == N_SAMPLES - 1) ? 1 : 0);
                end
                if (outCount < 128) begin
                    lastLog[outCount] = int'(out_last);
                    idxLog[outCount]  = int'(out_idx);
                end
                outCount++;
            end
            if (flush) begin
                expQ.delete();
                modelIdx = 0;
            end else if (out_valid && out_ready) begin
                modelIdx = (modelIdx + 1) % N_SAMPLES;
            end
            if (in_valid && in_ready) begin
                expQ.push_back(modelPel(int'(in_p0), int'(in_p1), int'(in_p2), int'(in_p3)));
            end
            stallPrev  = out_valid && !out_ready;
            flushPrev  = flush;
            prevSample = out_sample;
            prevIdx    = out_idx;
            prevLast   = out_last;
        end
    end

    // Present one sample and hold it until the DUT takes it (bounded).
    task automatic applyStimulus(input int a, input int b, input int c, input int d);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_p0    = PROD_W'(a);
        in_p1    = PROD_W'(b);
        in_p2    = PROD_W'(c);
        in_p3    = PROD_W'(d);
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) checkOutput("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    // Single sample through an idle pipeline with literal latency/value checks.
    task automatic sendLiteral(input string name, input int a, input int b, input int c,
                               input int d, input int expSample, input int expIdx);
        applyStimulus(a, b, c, d);
        checkOutput({name, "_lat1_valid"}, int'(out_valid), 0);
        @(posedge clk);
        #1;
        checkOutput({name, "_valid"}, int'(out_valid), 1);
        checkOutput({name, "_sample"}, int'(out_sample), expSample);
        if (expIdx >= 0) checkOutput({name, "_idx"}, int'(out_idx), expIdx);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && (expQ.size() != 0 || out_valid); t++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("drain_queue_empty", expQ.size(), 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lastCount;
        int countMark;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_p0     = '0;
        in_p1     = '0;
        in_p2     = '0;
        in_p3     = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_in_ready", int'(in_ready), 1);
        checkOutput("rst_out_sample", int'(out_sample), 0);
        checkOutput("rst_out_idx", int'(out_idx), 0);
        checkOutput("rst_out_last", int'(out_last), 0);

        // Pin the reference model to hand-computed values
        checkOutput("model_basic", modelPel(0, 6400, 0, 0), 100);
        checkOutput("model_rnd_m33", modelPel(-33, 0, 0, 0), 0);
        checkOutput("model_rnd_95", modelPel(95, 0, 0, 0), 1);
        checkOutput("model_clip_hi", modelPel(32767, 32767, 0, 0), 255);

        // Basic, rounding boundaries, clipping
        sendLiteral("basic", 0, 6400, 0, 0, 100, 0);
        sendLiteral("rnd31", 31, 0, 0, 0, 0, 1);
        sendLiteral("rnd32", 32, 0, 0, 0, 1, 2);
        sendLiteral("rnd95", 95, 0, 0, 0, 1, 3);
        sendLiteral("rndm33", -33, 0, 0, 0, 0, 4);
        sendLiteral("clip_hi", 32767, 32767, 0, 0, 255, 5);
        sendLiteral("clip_lo", -3000, 0, 0, 0, 0, 6);
        sendLiteral("mixed", 1000, -200, 3000, 4600, 131, 7);
        sendLiteral("allmax", 32767, 32767, 32767, 32767, 255, 8);
        drain();

        // Backpressure: 5 samples, consumer stalls 3 cycles mid-stream
        stallCycles = 0;
        countMark   = outCount;
        fork
            begin
                for (int i = 0; i < 5; i++) applyStimulus((i + 1) * 1000, 0, 0, 0);
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        checkOutput("bp_stall_seen", (stallCycles >= 3) ? 1 : 0, 1);
        checkOutput("bp_count", outCount - countMark, 5);

        // Row framing: start a fresh row then stream 70 samples
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        outCount = 0;
        for (int i = 0; i < 70; i++) applyStimulus(i * 97 - 500, i * 13, 0, 64);
        drain();
        lastCount = 0;
        for (int i = 0; i < 70; i++) lastCount += lastLog[i];
        checkOutput("row_count", outCount, 70);
        checkOutput("row_last_32", lastLog[31], 1);
        checkOutput("row_last_64", lastLog[63], 1);
        checkOutput("row_last_70", lastLog[69], 0);
        checkOutput("row_idx_32", idxLog[31], 31);
        checkOutput("row_idx_33", idxLog[32], 0);
        checkOutput("row_last_total", lastCount, 2);

        // Flush with two samples in flight while the consumer is stalled
        out_ready = 1'b0;
        applyStimulus(6400, 0, 0, 0);
        applyStimulus(3200, 0, 0, 0);
        checkOutput("fl_pre_valid", int'(out_valid), 1);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_p0    = 16'sd1280;
        @(negedge clk);
        checkOutput("fl_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("fl_out_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        checkOutput("fl_no_leak", int'(out_valid), 0);
        out_ready = 1'b1;
        sendLiteral("fl_next", 640, 0, 0, 0, 10, 0);

        // Asynchronous reset between edges with two samples in flight
        applyStimulus(1920, 0, 0, 0);
        applyStimulus(2560, 0, 0, 0);
        checkOutput("ar_pre_valid", int'(out_valid), 1);
        checkOutput("ar_pre_idx", int'(out_idx), 1);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("ar_out_valid", int'(out_valid), 0);
        checkOutput("ar_out_sample", int'(out_sample), 0);
        checkOutput("ar_out_idx", int'(out_idx), 0);
        checkOutput("ar_out_last", int'(out_last), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        sendLiteral("ar_next", 0, 0, 4480, 0, 70, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
